// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin share of one APB master between NUM_REQ
// requesters. One transfer in flight; completion is detected by monitoring
// the APB bus, and read data / error / done are returned to the owner.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          err_o,
    output logic                          trans_o,
    output logic [ADDR_WIDTH-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0]         wdata_o,
    output logic                          wr_rd_o,
    input  logic                          pselx_i,
    input  logic                          penable_i,
    input  logic                          pready_i,
    input  logic                          pslverr_i,
    input  logic [DATA_WIDTH-1:0]         prdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        own_q, own_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    trans_q, trans_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wr_q, wr_d;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    int unsigned             cand;

    // Round-robin pick: first pending request at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req_i[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic; done is a pulse so it defaults low
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        own_d    = own_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        trans_d  = trans_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        case (state_q)
            ST_IDLE: begin
                trans_d = 1'b0;
                if (win_found) begin
                    own_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    addr_d         = req_addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d        = req_wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    wr_d           = req_write_i[win_idx];
                    trans_d        = 1'b1;
                    state_d        = ST_REQ;
                end
            end
            ST_REQ: begin
                // Drop trans once the master is in setup so it idles after this access
                if (pselx_i && !penable_i) begin
                    trans_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                trans_d = 1'b0;
                if (pselx_i && penable_i && pready_i) begin
                    err_d = pslverr_i;
                    if (!wr_q) rdata_d = prdata_i;
                    done_d[own_q] = 1'b1;
                    gnt_d         = '0;
                    rr_ptr_d      = (int'(own_q) == NUM_REQ-1) ? '0 : own_q + 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                trans_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            own_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            trans_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            own_q    <= own_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            trans_q  <= trans_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign trans_o = trans_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign wr_rd_o = wr_q;

endmodule
